// File: rtl/maze_pkg.sv
// Shared maze definitions: grid geometry, cell encodings, direction and FSM state types.
package maze_pkg;

  localparam int GRID_DIM = 8;
  localparam int ADDR_W   = 6;
  localparam int CELL_W   = 2;
  localparam int COORD_W  = 3;

  localparam logic [CELL_W-1:0] CELL_FREE = 2'd0;
  localparam logic [CELL_W-1:0] CELL_WALL = 2'd1;
  localparam logic [CELL_W-1:0] CELL_GOAL = 2'd2;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_CHECK,
    ST_WIN
  } state_t;

  // Row-major address on an 8x8 grid: row*8 + col.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] row,
                                                  input logic [COORD_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/maze_player_ctrl_if.sv
// Read-only maze memory port: address/command out of the controller, cell value back.
interface maze_player_ctrl_if;
  import maze_pkg::*;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_command;
  logic [CELL_W-1:0] mem_data;

  modport master (output mem_address, output mem_command, input mem_data);
  modport slave  (input mem_address, input mem_command, output mem_data);

endinterface

// File: rtl/maze_step_calc.sv
// Combinational one-step move: target cell for a direction plus an off-grid flag.
module maze_step_calc
  import maze_pkg::*;
(
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  dir_t               dir,
  output logic [COORD_W-1:0] tgt_row,
  output logic [COORD_W-1:0] tgt_col,
  output logic [ADDR_W-1:0]  tgt_addr,
  output logic               off_grid
);

  localparam logic [COORD_W-1:0] EDGE_LO = '0;
  localparam logic [COORD_W-1:0] EDGE_HI = COORD_W'(GRID_DIM - 1);

  always_comb begin
    tgt_row  = row;
    tgt_col  = col;
    off_grid = 1'b0;
    case (dir)
      DIR_UP: begin
        if (row == EDGE_LO) off_grid = 1'b1;
        else                tgt_row  = row - 3'd1;
      end
      DIR_DOWN: begin
        if (row == EDGE_HI) off_grid = 1'b1;
        else                tgt_row  = row + 3'd1;
      end
      DIR_LEFT: begin
        if (col == EDGE_LO) off_grid = 1'b1;
        else                tgt_col  = col - 3'd1;
      end
      DIR_RIGHT: begin
        if (col == EDGE_HI) off_grid = 1'b1;
        else                tgt_col  = col + 3'd1;
      end
      default: off_grid = 1'b1;
    endcase
  end

  assign tgt_addr = cell_addr(tgt_row, tgt_col);

endmodule

// File: rtl/maze_player_ctrl.sv
// Player movement controller: button-driven moves validated by one maze memory read each.
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter logic [COORD_W-1:0] START_ROW = 3'd1,
  parameter logic [COORD_W-1:0] START_COL = 3'd4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  maze_player_ctrl_if.master mem,
  output logic [COORD_W-1:0] pos_row,
  output logic [COORD_W-1:0] pos_col,
  output logic               busy,
  output logic               bump,
  output logic               win,
  output logic [7:0]         move_count
);

  state_t             state;
  dir_t               dir;
  logic               any_btn;
  logic [COORD_W-1:0] step_row;
  logic [COORD_W-1:0] step_col;
  logic [ADDR_W-1:0]  step_addr;
  logic               step_off;
  logic [COORD_W-1:0] tgt_row;
  logic [COORD_W-1:0] tgt_col;
  logic [ADDR_W-1:0]  addr_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign any_btn = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    dir = DIR_RIGHT;
    if (btn_up)        dir = DIR_UP;
    else if (btn_down) dir = DIR_DOWN;
    else if (btn_left) dir = DIR_LEFT;
  end

  maze_step_calc u_step (
    .row      (pos_row),
    .col      (pos_col),
    .dir      (dir),
    .tgt_row  (step_row),
    .tgt_col  (step_col),
    .tgt_addr (step_addr),
    .off_grid (step_off)
  );

  assign mem.mem_address = addr_q;
  assign mem.mem_command = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pos_row    <= START_ROW;
      pos_col    <= START_COL;
      addr_q     <= cell_addr(START_ROW, START_COL);
      busy       <= 1'b0;
      bump       <= 1'b0;
      win        <= 1'b0;
      move_count <= 8'd0;
    end else begin
      bump <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_btn) begin
            // Off-grid moves are rejected without touching memory.
            if (step_off) begin
              bump <= 1'b1;
            end else begin
              tgt_row <= step_row;
              tgt_col <= step_col;
              addr_q  <= step_addr;
              busy    <= 1'b1;
              state   <= ST_REQ;
            end
          end
        end
        ST_REQ: state <= ST_CHECK;
        ST_CHECK: begin
          busy <= 1'b0;
          // On acceptance addr_q already holds the new position's address.
          case (mem.mem_data)
            CELL_FREE: begin
              pos_row    <= tgt_row;
              pos_col    <= tgt_col;
              move_count <= sat_inc(move_count);
              state      <= ST_IDLE;
            end
            CELL_GOAL: begin
              pos_row    <= tgt_row;
              pos_col    <= tgt_col;
              move_count <= sat_inc(move_count);
              win        <= 1'b1;
              state      <= ST_WIN;
            end
            default: begin
              bump   <= 1'b1;
              addr_q <= cell_addr(pos_row, pos_col);
              state  <= ST_IDLE;
            end
          endcase
        end
        ST_WIN:  state <= ST_WIN;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Bench for maze_player_ctrl: timeline model of the default instance plus directed literal checks.
module tb_maze_player_ctrl;
  import maze_pkg::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst = 1'b1;
  logic bu = 0, bd = 0, bl = 0, br = 0;
  logic ub = 0, db = 0, lb = 0, rb = 0;

  maze_player_ctrl_if mif_a ();
  maze_player_ctrl_if mif_b ();

  logic [2:0] row_a, col_a, row_b, col_b;
  logic       busy_a, bump_a, win_a, busy_b, bump_b, win_b;
  logic [7:0] cnt_a, cnt_b;

  logic [1:0] lay_a [64];
  logic [1:0] lay_b [64];

  assign mif_a.mem_data = lay_a[mif_a.mem_address];
  assign mif_b.mem_data = lay_b[mif_b.mem_address];

  maze_player_ctrl dut_a (
    .clk(clk), .rst(rst),
    .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
    .mem(mif_a),
    .pos_row(row_a), .pos_col(col_a),
    .busy(busy_a), .bump(bump_a), .win(win_a), .move_count(cnt_a)
  );

  maze_player_ctrl #(.START_ROW(3'd0), .START_COL(3'd0)) dut_b (
    .clk(clk), .rst(rst),
    .btn_up(ub), .btn_down(db), .btn_left(lb), .btn_right(rb),
    .mem(mif_b),
    .pos_row(row_b), .pos_col(col_b),
    .busy(busy_b), .bump(bump_b), .win(win_b), .move_count(cnt_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of dut_a: position, count, win, and a countdown for the two-cycle memory check.
  int m_row, m_col, m_cnt, m_pend, t_row, t_col, dr, dc;
  bit m_win, m_bump, m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_row = 1; m_col = 4; m_cnt = 0; m_win = 0; m_bump = 0; m_pend = 0; m_valid = 1;
    end else if (m_valid) begin
      m_bump = 0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          if (lay_a[t_row*8 + t_col] == 2'd0 || lay_a[t_row*8 + t_col] == 2'd2) begin
            m_row = t_row; m_col = t_col;
            if (m_cnt < 255) m_cnt++;
            if (lay_a[t_row*8 + t_col] == 2'd2) m_win = 1;
          end else begin
            m_bump = 1;
          end
        end
      end else if (!m_win && (bu || bd || bl || br)) begin
        dr = 0; dc = 0;
        if (bu)      dr = -1;
        else if (bd) dr = 1;
        else if (bl) dc = -1;
        else         dc = 1;
        t_row = m_row + dr;
        t_col = m_col + dc;
        if (t_row < 0 || t_row > 7 || t_col < 0 || t_col > 7) m_bump = 1;
        else m_pend = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("a_pos_row", row_a, m_row);
      chk("a_pos_col", col_a, m_col);
      chk("a_mem_address", mif_a.mem_address, (m_pend > 0) ? t_row*8 + t_col : m_row*8 + m_col);
      chk("a_busy", busy_a, (m_pend > 0));
      chk("a_bump", bump_a, m_bump);
      chk("a_win", win_a, m_win);
      chk("a_move_count", cnt_a, m_cnt);
      chk("a_mem_command", mif_a.mem_command, 1);
    end
  end

  task automatic press_a(input logic [3:0] m);
    @(posedge clk); #1; {bu, bd, bl, br} = m;
    @(posedge clk); #1; {bu, bd, bl, br} = 4'b0;
  endtask

  task automatic press_b(input logic [3:0] m);
    @(posedge clk); #1; {ub, db, lb, rb} = m;
    @(posedge clk); #1; {ub, db, lb, rb} = 4'b0;
  endtask

  task automatic settle;
    int k;
    k = 0;
    while ((busy_a || busy_b) && k < 10) begin
      @(posedge clk); #1; k++;
    end
    if (busy_a || busy_b) chk("settle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // Rejected up move from (1,4): reads address 4 for two cycles, then bumps.
  task automatic expect_up_bump(input logic [3:0] m);
    press_a(m);
    chk("up_req_addr", mif_a.mem_address, 4);
    chk("up_req_busy", busy_a, 1);
    @(posedge clk); #1;
    chk("up_chk_addr", mif_a.mem_address, 4);
    @(posedge clk); #1;
    chk("up_bump", bump_a, 1);
    chk("up_row", row_a, 1);
    chk("up_col", col_a, 4);
    chk("up_addr_back", mif_a.mem_address, 12);
    chk("up_cnt", cnt_a, 0);
    @(posedge clk); #1;
    chk("up_bump_clear", bump_a, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      lay_a[i] = 2'd1;
      lay_b[i] = 2'd0;
    end
    lay_a[12] = 2'd0; lay_a[20] = 2'd0; lay_a[19] = 2'd0; lay_a[18] = 2'd0;
    lay_a[17] = 2'd0; lay_a[25] = 2'd0; lay_a[33] = 2'd0; lay_a[41] = 2'd0;
    lay_a[49] = 2'd0; lay_a[48] = 2'd2; lay_a[21] = 2'd3;

    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_row", row_a, 1);
    chk("rst_col", col_a, 4);
    chk("rst_addr", mif_a.mem_address, 12);
    chk("rst_win", win_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_b_addr", mif_b.mem_address, 0);

    // Corner instance: off-grid left and up bump at once without a memory cycle.
    press_b(4'b0010);
    chk("b_left_bump", bump_b, 1);
    chk("b_left_busy", busy_b, 0);
    chk("b_left_addr", mif_b.mem_address, 0);
    @(posedge clk); #1;
    chk("b_left_bump_clear", bump_b, 0);
    chk("b_left_busy2", busy_b, 0);
    chk("b_left_col", col_b, 0);
    press_b(4'b1000);
    chk("b_up_bump", bump_b, 1);
    chk("b_up_busy", busy_b, 0);
    press_b(4'b0001);
    settle();
    chk("b_right_col", col_b, 1);
    chk("b_right_cnt", cnt_b, 1);

    expect_up_bump(4'b1000);
    expect_up_bump(4'b1010);

    // Down to (2,4), then right onto an undefined cell value.
    press_a(4'b0100); settle();
    chk("down_row", row_a, 2);
    chk("down_cnt", cnt_a, 1);
    press_a(4'b0001); settle();
    chk("undef_col", col_a, 4);
    chk("undef_cnt", cnt_a, 1);

    // Down into a wall while a left pulse arrives during busy; the left is dropped.
    @(posedge clk); #1; bd = 1'b1;
    @(posedge clk); #1; bd = 1'b0; bl = 1'b1;
    @(posedge clk); #1; bl = 1'b0;
    settle();
    chk("drop_row", row_a, 2);
    chk("drop_col", col_a, 4);

    // Reset lands during CHECK of an accepted move.
    do_reset();
    press_a(4'b0100);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rstchk_row", row_a, 1);
    chk("rstchk_bump", bump_a, 0);
    chk("rstchk_busy", busy_a, 0);
    @(posedge clk); #1;
    chk("rstchk_bump2", bump_a, 0);
    chk("rstchk_cnt", cnt_a, 0);

    // Saturation: 260 accepted moves shuttling between (1,4) and (2,4).
    for (int i = 0; i < 130; i++) begin
      press_a(4'b0100); settle();
      press_a(4'b1000); settle();
    end
    chk("sat_cnt", cnt_a, 255);
    chk("sat_row", row_a, 1);

    // Path to the goal at (6,0).
    do_reset();
    press_a(4'b0100); settle();
    repeat (3) begin press_a(4'b0010); settle(); end
    repeat (4) begin press_a(4'b0100); settle(); end
    press_a(4'b0010); settle();
    chk("goal_row", row_a, 6);
    chk("goal_col", col_a, 0);
    chk("goal_addr", mif_a.mem_address, 48);
    chk("goal_win", win_a, 1);
    chk("goal_cnt", cnt_a, 9);
    press_a(4'b0001); settle();
    press_a(4'b1000); settle();
    press_a(4'b1111); settle();
    chk("win_hold_col", col_a, 0);
    chk("win_hold_cnt", cnt_a, 9);
    chk("win_hold_win", win_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
